// File: rtl/mux4_arb_pkg.sv
// Shared types, sizes and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of mask from ptr upward, wrapping 3->0.
// Zero latency; no flow control, any=0 means win is don't-care.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  // Scan from the far end down so the nearest set bit to ptr is assigned last.
  always_comb begin
    win = ptr;
    any = |mask;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (mask[ptr + SEL_W'(i)]) win = ptr + SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4-to-1 mux select; registered one-hot grant, 1 cycle req->gnt.
// Grants hold until the owner drops req or MAX_HOLD cycles elapse; handover has no bubble.
module mux4_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             sel_valid,
  output logic             timeout,
  output logic [1:0]       owner_dbg
);

  import mux4_arb_pkg::*;

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] owner;
  logic [HC_W-1:0]  hold_cnt;

  logic             drop_vol;
  logic             limit_hit;
  logic             rel;
  logic [N_REQ-1:0] pick_mask;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] win;
  logic             win_any;
  logic [N_REQ-1:0] win_oh;

  assign drop_vol  = ~req[owner];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign rel       = drop_vol || limit_hit;

  // On release the departing owner is masked out and priority starts just past it.
  assign pick_mask = (state == BUSY) ? (req & ~(N_REQ'(1) << owner)) : req;
  assign pick_ptr  = (state == BUSY) ? owner + 2'd1 : ptr;
  assign win_oh    = N_REQ'(1) << win;
  assign owner_dbg = owner;

  rr_pick u_pick (
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .win  (win),
    .any  (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE || rel) begin
        if (state == BUSY) begin
          ptr     <= owner + 2'd1;
          timeout <= ~drop_vol;
        end
        if (win_any) begin
          state     <= BUSY;
          gnt       <= win_oh;
          sel       <= onehot_to_idx(win_oh);
          sel_valid <= 1'b1;
          owner     <= win;
          hold_cnt  <= '0;
        end else begin
          state     <= IDLE;
          gnt       <= '0;
          sel_valid <= 1'b0;
        end
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
